// File: rtl/writeback_queue_pkg.sv
// Shared writeback types: register-file geometry and the {addr, data} result record
// exchanged between producers and the writeback queue.
package writeback_queue_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_lookup.sv
// Bypass match over the pending queue entries plus the output stage; youngest match wins.
// Purely combinational, no backpressure; a miss returns hit=0, data=0.
module writeback_lookup
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  wb_entry_t [DEPTH-1:0]    entries_i,
   input  logic [$clog2(DEPTH)-1:0] head_i,
   input  logic [$clog2(DEPTH):0]   count_i,
   input  logic                     out_vld_i,
   input  wb_entry_t                out_i,
   input  logic [ADDR_W-1:0]        addr_i,
   output logic                     hit_o,
   output logic [DATA_W-1:0]        data_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;

   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      // Offset i counts from the head, so the highest occupied offset is the youngest entry.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         idx = head_i + PTR_W'(i);
         if (!hit_o && (CNT_W'(i) < count_i) && (entries_i[idx].addr == addr_i)) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data;
         end
      end
      if (!hit_o && out_vld_i && (out_i.addr == addr_i)) begin
         hit_o  = 1'b1;
         data_o = out_i.data;
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO: Mem/ALU results in, one registered register-file write per cycle out.
// Push at edge N retires at edge N+1 when empty; Ready looks at Count only (no same-cycle pop credit).
module writeback_queue
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   AluValid,
   input  logic [ADDR_W-1:0]      AluAddr,
   input  logic [DATA_W-1:0]      AluData,
   output logic                   AluReady,
   input  logic                   MemValid,
   input  logic [ADDR_W-1:0]      MemAddr,
   input  logic [DATA_W-1:0]      MemData,
   output logic                   MemReady,
   output logic                   RegWr,
   output logic [ADDR_W-1:0]      Waddr,
   output logic [DATA_W-1:0]      Writedata,
   input  logic [ADDR_W-1:0]      LookAddr1,
   input  logic [ADDR_W-1:0]      LookAddr2,
   output logic                   LookHit1,
   output logic                   LookHit2,
   output logic [DATA_W-1:0]      LookData1,
   output logic [DATA_W-1:0]      LookData2,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Full,
   output logic                   Empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] ROOM1 = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] ROOM2 = CNT_W'(DEPTH - 2);

   wb_entry_t [DEPTH-1:0] entries_q;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  reg_wr_q;
   wb_entry_t             out_q;

   logic                  mem_rdy, alu_rdy;
   logic                  mem_push, alu_push, pop;
   logic [PTR_W-1:0]      alu_slot;

   // Both pushes must fit even if nothing pops this cycle.
   assign mem_rdy  = !RESET && (count_q <= ROOM1);
   assign alu_rdy  = !RESET && (MemValid ? (count_q <= ROOM2) : (count_q <= ROOM1));
   assign mem_push = MemValid && mem_rdy;
   assign alu_push = AluValid && alu_rdy;

   always_comb begin
      pop      = (count_q != '0);
      head_d   = head_q + PTR_W'(pop);
      tail_d   = tail_q + PTR_W'(mem_push) + PTR_W'(alu_push);
      count_d  = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
      alu_slot = tail_q + PTR_W'(mem_push);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         reg_wr_q <= 1'b0;
         out_q    <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         reg_wr_q <= pop;
         if (pop) begin
            out_q <= entries_q[head_q];
         end
      end
   end

   // Entry storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge CLK) begin
      if (mem_push) begin
         entries_q[tail_q] <= '{addr: MemAddr, data: MemData};
      end
      if (alu_push) begin
         entries_q[alu_slot] <= '{addr: AluAddr, data: AluData};
      end
   end

   logic              hit1, hit2;
   logic [DATA_W-1:0] data1, data2;

   writeback_lookup #(.DEPTH(DEPTH)) u_look1 (
      .entries_i (entries_q),
      .head_i    (head_q),
      .count_i   (count_q),
      .out_vld_i (reg_wr_q),
      .out_i     (out_q),
      .addr_i    (LookAddr1),
      .hit_o     (hit1),
      .data_o    (data1)
   );

   writeback_lookup #(.DEPTH(DEPTH)) u_look2 (
      .entries_i (entries_q),
      .head_i    (head_q),
      .count_i   (count_q),
      .out_vld_i (reg_wr_q),
      .out_i     (out_q),
      .addr_i    (LookAddr2),
      .hit_o     (hit2),
      .data_o    (data2)
   );

   assign LookHit1  = !RESET && hit1;
   assign LookHit2  = !RESET && hit2;
   assign LookData1 = RESET ? '0 : data1;
   assign LookData2 = RESET ? '0 : data2;

   assign AluReady  = alu_rdy;
   assign MemReady  = mem_rdy;
   assign RegWr     = reg_wr_q;
   assign Waddr     = out_q.addr;
   assign Writedata = out_q.data;
   assign Count     = count_q;
   assign Full      = (count_q == CNT_W'(DEPTH));
   assign Empty     = (count_q == '0);

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_writeback_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        AluValid, MemValid;
   logic [3:0]  AluAddr, MemAddr, LookAddr1, LookAddr2;
   logic [31:0] AluData, MemData;
   logic        AluReady, MemReady, RegWr, LookHit1, LookHit2, Full, Empty;
   logic [3:0]  Waddr;
   logic [31:0] Writedata, LookData1, LookData2;
   logic [2:0]  Count;

   int n_checks = 0;
   int n_pass   = 0;

   ent_t mq[$];
   bit   m_wr;
   ent_t m_out;

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET),
      .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
      .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
      .RegWr(RegWr), .Waddr(Waddr), .Writedata(Writedata),
      .LookAddr1(LookAddr1), .LookAddr2(LookAddr2),
      .LookHit1(LookHit1), .LookHit2(LookHit2), .LookData1(LookData1), .LookData2(LookData2),
      .Count(Count), .Full(Full), .Empty(Empty)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      AluValid = 1'b0;
      MemValid = 1'b0;
   endtask

   task automatic push_mem(input logic [3:0] a, input logic [31:0] d);
      MemValid = 1'b1; MemAddr = a; MemData = d;
   endtask

   task automatic push_alu(input logic [3:0] a, input logic [31:0] d);
      AluValid = 1'b1; AluAddr = a; AluData = d;
   endtask

   // Reference model: a plain FIFO of pending results plus the last retired result.
   function automatic void model_reset();
      mq.delete();
      m_wr  = 1'b0;
      m_out = '0;
   endfunction

   function automatic void model_step(input bit mv, input ent_t me, input bit av, input ent_t ae);
      int n;
      bit mr, ar;
      n  = mq.size();
      mr = (n <= DEPTH - 1);
      ar = mv ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
      if (n > 0) begin
         m_wr  = 1'b1;
         m_out = mq.pop_front();
      end else begin
         m_wr = 1'b0;
      end
      if (mv && mr) mq.push_back(me);
      if (av && ar) mq.push_back(ae);
   endfunction

   function automatic void model_look(input logic [3:0] addr, output bit hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].a == addr) begin
            hit = 1'b1;
            d   = mq[i].d;
            break;
         end
      end
      if (!hit && m_wr && (m_out.a == addr)) begin
         hit = 1'b1;
         d   = m_out.d;
      end
   endfunction

   task automatic test_reset();
      RESET = 1'b1;
      push_mem(4'd1, 32'h1); push_alu(4'd2, 32'h2);
      LookAddr1 = 4'd1; LookAddr2 = 4'd2;
      tick(); tick();
      n_checks++; if (MemReady !== 1'b0) $display("FAIL rst_memready: got %0b want 0", MemReady); else n_pass++;
      n_checks++; if (AluReady !== 1'b0) $display("FAIL rst_aluready: got %0b want 0", AluReady); else n_pass++;
      n_checks++; if (LookHit1 !== 1'b0 || LookHit2 !== 1'b0) $display("FAIL rst_lookhit: got %0b%0b want 00", LookHit1, LookHit2); else n_pass++;
      RESET = 1'b0;
      idle();
      #1;
      n_checks++; if (Count !== 3'd0) $display("FAIL rst_count: got %0d want 0", Count); else n_pass++;
      n_checks++; if (RegWr !== 1'b0 || Waddr !== 4'd0 || Writedata !== 32'd0)
         $display("FAIL rst_output: got wr=%0b a=%0d d=%h want 0/0/0", RegWr, Waddr, Writedata); else n_pass++;
      n_checks++; if (Empty !== 1'b1 || Full !== 1'b0) $display("FAIL rst_flags: got E=%0b F=%0b want 1/0", Empty, Full); else n_pass++;
      n_checks++; if (MemReady !== 1'b1 || AluReady !== 1'b1) $display("FAIL rst_ready_after: got %0b%0b want 11", MemReady, AluReady); else n_pass++;
   endtask

   task automatic test_single();
      push_alu(4'd3, 32'h0000_00AA);
      #1;
      n_checks++; if (AluReady !== 1'b1) $display("FAIL single_ready: got %0b want 1", AluReady); else n_pass++;
      tick(); idle(); #1;
      n_checks++; if (Count !== 3'd1 || RegWr !== 1'b0) $display("FAIL single_queued: got cnt=%0d wr=%0b want 1/0", Count, RegWr); else n_pass++;
      tick(); LookAddr1 = 4'd3; #1;
      n_checks++; if (RegWr !== 1'b1 || Waddr !== 4'd3 || Writedata !== 32'hAA)
         $display("FAIL single_write: got wr=%0b a=%0d d=%h want 1/3/aa", RegWr, Waddr, Writedata); else n_pass++;
      n_checks++; if (LookHit1 !== 1'b1 || LookData1 !== 32'hAA) $display("FAIL single_outlook: got %0b/%h want 1/aa", LookHit1, LookData1); else n_pass++;
      tick(); #1;
      n_checks++; if (RegWr !== 1'b0 || Empty !== 1'b1 || Waddr !== 4'd3 || Writedata !== 32'hAA)
         $display("FAIL single_after: got wr=%0b E=%0b a=%0d d=%h want 0/1/3/aa", RegWr, Empty, Waddr, Writedata); else n_pass++;
   endtask

   task automatic test_dual();
      push_mem(4'd1, 32'h11); push_alu(4'd2, 32'h22);
      #1;
      n_checks++; if (MemReady !== 1'b1 || AluReady !== 1'b1) $display("FAIL dual_ready: got %0b%0b want 11", MemReady, AluReady); else n_pass++;
      tick(); idle(); #1;
      n_checks++; if (Count !== 3'd2 || RegWr !== 1'b0) $display("FAIL dual_cnt2: got cnt=%0d wr=%0b want 2/0", Count, RegWr); else n_pass++;
      tick(); #1;
      n_checks++; if (RegWr !== 1'b1 || Waddr !== 4'd1 || Writedata !== 32'h11 || Count !== 3'd1)
         $display("FAIL dual_first: got wr=%0b a=%0d d=%h cnt=%0d want 1/1/11/1", RegWr, Waddr, Writedata, Count); else n_pass++;
      tick(); #1;
      n_checks++; if (RegWr !== 1'b1 || Waddr !== 4'd2 || Writedata !== 32'h22 || Count !== 3'd0)
         $display("FAIL dual_second: got wr=%0b a=%0d d=%h cnt=%0d want 1/2/22/0", RegWr, Waddr, Writedata, Count); else n_pass++;
      tick(); #1;
      n_checks++; if (RegWr !== 1'b0) $display("FAIL dual_idle: got wr=%0b want 0", RegWr); else n_pass++;
   endtask

   task automatic test_ready_limits();
      push_mem(4'd7, 32'h70); push_alu(4'd8, 32'h80);
      tick();
      push_mem(4'd9, 32'h90); push_alu(4'd10, 32'hA0);
      #1;
      n_checks++; if (AluReady !== 1'b1) $display("FAIL lim_cnt2_alu: got %0b want 1", AluReady); else n_pass++;
      tick(); #1;
      n_checks++; if (Count !== 3'd3 || Full !== 1'b0) $display("FAIL lim_cnt3: got cnt=%0d F=%0b want 3/0", Count, Full); else n_pass++;
      n_checks++; if (MemReady !== 1'b1 || AluReady !== 1'b0) $display("FAIL lim_both_valid: got mem=%0b alu=%0b want 1/0", MemReady, AluReady); else n_pass++;
      MemValid = 1'b0; #1;
      n_checks++; if (AluReady !== 1'b1) $display("FAIL lim_alu_only: got %0b want 1", AluReady); else n_pass++;
      idle();
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (Empty !== 1'b1) $display("FAIL lim_drain: got E=%0b want 1", Empty); else n_pass++;
   endtask

   task automatic test_lookup();
      push_mem(4'd5, 32'h10); push_alu(4'd5, 32'h20);
      tick(); idle(); LookAddr1 = 4'd5; LookAddr2 = 4'd6; #1;
      n_checks++; if (LookHit1 !== 1'b1 || LookData1 !== 32'h20) $display("FAIL look_youngest: got %0b/%h want 1/20", LookHit1, LookData1); else n_pass++;
      n_checks++; if (LookHit2 !== 1'b0 || LookData2 !== 32'h0) $display("FAIL look_miss: got %0b/%h want 0/0", LookHit2, LookData2); else n_pass++;
      tick(); #1;
      n_checks++; if (Writedata !== 32'h10 || LookHit1 !== 1'b1 || LookData1 !== 32'h20)
         $display("FAIL look_queue_over_out: got wd=%h hit=%0b d=%h want 10/1/20", Writedata, LookHit1, LookData1); else n_pass++;
      tick(); #1;
      n_checks++; if (LookHit1 !== 1'b1 || LookData1 !== 32'h20) $display("FAIL look_outreg: got %0b/%h want 1/20", LookHit1, LookData1); else n_pass++;
      tick(); #1;
      n_checks++; if (LookHit1 !== 1'b0 || LookData1 !== 32'h0) $display("FAIL look_gone: got %0b/%h want 0/0", LookHit1, LookData1); else n_pass++;
   endtask

   task automatic test_wraparound();
      ent_t exp_q[$];
      ent_t e;
      int   got = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 10) begin
            e.a = 4'(i);
            e.d = $urandom;
            exp_q.push_back(e);
            push_alu(e.a, e.d);
         end else begin
            idle();
         end
         tick();
         if (RegWr === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL wrap_extra: got write a=%0d d=%h want none", Waddr, Writedata);
            end else begin
               e = exp_q.pop_front();
               if (Waddr !== e.a || Writedata !== e.d)
                  $display("FAIL wrap_order: got a=%0d d=%h want a=%0d d=%h", Waddr, Writedata, e.a, e.d);
               else n_pass++;
            end
            got++;
         end
      end
      n_checks++; if (got != 10) $display("FAIL wrap_count: got %0d writes want 10", got); else n_pass++;
   endtask

   task automatic test_reset_midop();
      push_mem(4'd1, 32'h101); push_alu(4'd2, 32'h202);
      tick();
      push_mem(4'd3, 32'h303); push_alu(4'd4, 32'h404);
      tick();
      RESET = 1'b1; LookAddr1 = 4'd3; LookAddr2 = 4'd4; #1;
      n_checks++; if (Count !== 3'd3) $display("FAIL mid_pending: got cnt=%0d want 3", Count); else n_pass++;
      n_checks++; if (MemReady !== 1'b0 || AluReady !== 1'b0) $display("FAIL mid_ready: got %0b%0b want 00", MemReady, AluReady); else n_pass++;
      n_checks++; if (LookHit1 !== 1'b0 || LookHit2 !== 1'b0 || LookData1 !== 32'h0)
         $display("FAIL mid_look: got %0b%0b d=%h want 00/0", LookHit1, LookHit2, LookData1); else n_pass++;
      tick(); #1;
      n_checks++; if (Count !== 3'd0 || RegWr !== 1'b0 || Waddr !== 4'd0 || Writedata !== 32'd0)
         $display("FAIL mid_cleared: got cnt=%0d wr=%0b a=%0d d=%h want 0/0/0/0", Count, RegWr, Waddr, Writedata); else n_pass++;
      RESET = 1'b0; idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (RegWr !== 1'b0) $display("FAIL mid_no_write: got wr=%0b at cycle %0d want 0", RegWr, i); else n_pass++;
      end
   endtask

   task automatic test_random();
      ent_t        me, ae;
      int          n;
      bit          emr, ear, eh;
      logic [31:0] ed;
      RESET = 1'b1; idle();
      tick();
      RESET = 1'b0;
      model_reset();
      for (int c = 0; c < 400; c++) begin
         MemValid  = ($urandom_range(0, 99) < 55);
         MemAddr   = 4'($urandom_range(0, 3));
         MemData   = $urandom;
         AluValid  = ($urandom_range(0, 99) < 60);
         AluAddr   = 4'($urandom_range(0, 3));
         AluData   = $urandom;
         LookAddr1 = 4'($urandom_range(0, 4));
         LookAddr2 = 4'($urandom_range(0, 4));
         #1;
         n   = mq.size();
         emr = (n <= DEPTH - 1);
         ear = MemValid ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
         n_checks++; if (Count !== 3'(n) || Full !== (n == DEPTH) || Empty !== (n == 0))
            $display("FAIL rnd_count c%0d: got cnt=%0d F=%0b E=%0b want cnt=%0d", c, Count, Full, Empty, n); else n_pass++;
         n_checks++; if (MemReady !== emr || AluReady !== ear)
            $display("FAIL rnd_ready c%0d: got mem=%0b alu=%0b want %0b/%0b", c, MemReady, AluReady, emr, ear); else n_pass++;
         n_checks++; if (RegWr !== m_wr || Waddr !== m_out.a || Writedata !== m_out.d)
            $display("FAIL rnd_write c%0d: got wr=%0b a=%0d d=%h want %0b/%0d/%h", c, RegWr, Waddr, Writedata, m_wr, m_out.a, m_out.d); else n_pass++;
         model_look(LookAddr1, eh, ed);
         n_checks++; if (LookHit1 !== eh || LookData1 !== ed)
            $display("FAIL rnd_look1 c%0d: got %0b/%h want %0b/%h", c, LookHit1, LookData1, eh, ed); else n_pass++;
         model_look(LookAddr2, eh, ed);
         n_checks++; if (LookHit2 !== eh || LookData2 !== ed)
            $display("FAIL rnd_look2 c%0d: got %0b/%h want %0b/%h", c, LookHit2, LookData2, eh, ed); else n_pass++;
         me = '{a: MemAddr, d: MemData};
         ae = '{a: AluAddr, d: AluData};
         tick();
         model_step(MemValid, me, AluValid, ae);
      end
      idle();
   endtask

   initial begin
      RESET = 1'b1;
      AluValid = 1'b0; AluAddr = '0; AluData = '0;
      MemValid = 1'b0; MemAddr = '0; MemData = '0;
      LookAddr1 = '0; LookAddr2 = '0;
      test_reset();
      test_single();
      test_dual();
      test_ready_limits();
      test_lookup();
      test_wraparound();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Writeback queue between the execute/memory stages and the 16 x 32-bit register file write port. Accepts results from two producers (ALU and memory load path), buffers them in a small in-order FIFO, and retires at most one per cycle onto the register file's single write port (RegWr/Waddr/Writedata). Also provides a two-port bypass lookup so operand fetch can read values that are pending but not yet in the register file.

## Interface
- DEPTH, 4, number of queue entries; power of two, >= 2
- DATA_W, 32, result width
- ADDR_W, 4, register address width (16 registers)
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- AluValid  in  1  ALU result present this cycle
- AluAddr  in  ADDR_W  ALU destination register
- AluData  in  DATA_W  ALU result
- AluReady  out  1  queue accepts ALU result this cycle
- MemValid  in  1  load result present this cycle
- MemAddr  in  ADDR_W  load destination register
- MemData  in  DATA_W  load data
- MemReady  out  1  queue accepts load result this cycle
- RegWr  out  1  register file write enable (registered)
- Waddr  out  ADDR_W  register file write address (registered)
- Writedata  out  DATA_W  register file write data (registered)
- LookAddr1, LookAddr2  in  ADDR_W  bypass lookup addresses
- LookHit1, LookHit2  out  1  pending value exists for address
- LookData1, LookData2  out  DATA_W  youngest pending value; 0 when no hit
- Count  out  log2(DEPTH)+1  occupied entries
- Full, Empty  out  1  Count == DEPTH / Count == 0

## Operation
- Push: a source transfers when Valid && Ready in the same cycle. Both may push in one cycle; Mem entry is enqueued first (older), ALU entry second.
- Ready uses Count only, no credit for a same-cycle pop: MemReady = Count <= DEPTH-1; AluReady = Count <= DEPTH-1 when !MemValid, Count <= DEPTH-2 when MemValid.
- Pop: each posedge, if Empty is false, head entry moves into the output register, RegWr=1, head pointer advances; otherwise RegWr=0 (Waddr/Writedata hold last values).
- Push and pop in the same cycle are both performed; Count changes by pushes minus pop (range -1..+2).
- Pointers are ADDR bits of log2(DEPTH), wrap modulo DEPTH; Count disambiguates full/empty.
- Lookup (combinational): search queue entries youngest to oldest, then the output register when RegWr=1; first address match wins. Same-cycle incoming pushes are not searched. No match -> Hit=0, Data=0.
- All 16 addresses, including 0, are ordinary destinations.
- RESET: pointers and Count to 0, RegWr=0, Waddr=0, Writedata=0. While RESET is high, AluReady, MemReady, LookHit1/2 are forced 0. Reset mid-operation discards all pending entries; no write is issued for them.

## Timing
- Result pushed at posedge N reaches RegWr/Waddr/Writedata at the earliest after posedge N+1 (queue empty, no older entries); the register file captures it on the negedge within that cycle.
- Entry is visible to lookup from after posedge N until the end of the cycle in which it sits in the output register.
- Sustained throughput: one retire per cycle; two pushes per cycle only until Full.
- After RESET deasserts at posedge R, Ready outputs are 1 in cycle R (Count=0).

## Structure
- Shared package: DATA_W, ADDR_W constants and a wb_entry struct {addr, data} used by producers and this queue.
- One sub-module: writeback_lookup, a parameterised youngest-first priority match over DEPTH entries plus the output stage; instantiated twice (lookup ports 1 and 2).

## Test plan
- Single ALU push {r3, 0x0000_00AA} into empty queue -> next cycle RegWr=1, Waddr=3, Writedata=0xAA; following cycle RegWr=0, Empty=1.
- Simultaneous MemValid {r1, 0x11} and AluValid {r2, 0x22} -> retires r1 then r2 on consecutive cycles; Count goes 0->2->1->0.
- Fill to DEPTH=4 with pushes, no room -> Full=1, MemReady=0, AluReady=0; with Count=3 and both valid, MemReady=1, AluReady=0.
- Queue holds r5=0x10 (older) and r5=0x20 (younger), LookAddr1=5, LookAddr2=6 -> LookHit1=1, LookData1=0x20, LookHit2=0, LookData2=0.
- Wrap-around: 10 back-to-back single pushes with continuous draining -> writes appear in exact push order, no loss or duplicate.
- Assert RESET with 3 entries pending -> next cycle Count=0, RegWr=0, Waddr=0, Writedata=0, no further writes; Ready and LookHit low while RESET is high.
